// File: rtl/rst_req_ctrl_pkg.sv
// Shared definitions for the soft-reset request controller: FSM encoding,
// cause bit positions, default parameter values and a counter-width helper.
package rst_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_DONE = 2'd2
  } rst_state_t;

  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WDT = 1;

  localparam int          DEF_HOLD_CYCLES  = 16;
  localparam int          DEF_DONE_TIMEOUT = 1024;
  localparam logic [23:0] DEF_WDT_LIMIT    = 24'd12500000;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_req_ctrl_if.sv
// Host-side signal bundle of the soft-reset controller. The master modport is
// the host register file / bench, the slave modport is the controller itself.
interface rst_req_ctrl_if;

  logic       i_sw_rst_req;
  logic       i_wdt_en;
  logic       i_wdt_kick;
  logic       i_rst_done;
  logic       i_err_clr;
  logic       o_soft_rst_n;
  logic       o_busy;
  logic [1:0] o_rst_cause;
  logic [7:0] o_rst_cnt;
  logic       o_timeout_err;

  modport master (
    output i_sw_rst_req,
    output i_wdt_en,
    output i_wdt_kick,
    output i_rst_done,
    output i_err_clr,
    input  o_soft_rst_n,
    input  o_busy,
    input  o_rst_cause,
    input  o_rst_cnt,
    input  o_timeout_err
  );

  modport slave (
    input  i_sw_rst_req,
    input  i_wdt_en,
    input  i_wdt_kick,
    input  i_rst_done,
    input  i_err_clr,
    output o_soft_rst_n,
    output o_busy,
    output o_rst_cause,
    output o_rst_cnt,
    output o_timeout_err
  );

endinterface

// File: rtl/rst_wdt.sv
// Watchdog for the soft-reset controller. Counts while running, is cleared by
// a kick, and flags expiry for one cycle when the limit is reached unkicked.
module rst_wdt
  import rst_pkg::*;
#(
  parameter logic [23:0] WDT_LIMIT = DEF_WDT_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,     // enabled and controller idle
  input  logic i_kick,
  output logic o_expire
);

  logic [23:0] wdt_cnt_reg;
  logic        at_limit;

  assign at_limit = (wdt_cnt_reg == (WDT_LIMIT - 24'd1));

  // A kick in the expiry cycle wins, so a late service still saves the system.
  assign o_expire = i_run && at_limit && !i_kick;

  // Counter: held at zero while not running, restarts on kick or expiry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdt_cnt_reg <= 24'd0;
    end else if (!i_run || i_kick || o_expire) begin
      wdt_cnt_reg <= 24'd0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_reg + 24'd1;
    end
  end

endmodule

// File: rtl/rst_req_ctrl.sv
// Soft-reset initiator: merges host and watchdog reset requests, drives a
// stretched active-low reset request, waits for the core to come back and
// reports cause, count and timeout status.
module rst_req_ctrl
  import rst_pkg::*;
#(
  parameter int          HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int          DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter logic [23:0] WDT_LIMIT    = DEF_WDT_LIMIT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rst_req_ctrl_if.slave  bus
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int WAIT_W = cnt_width(DONE_TIMEOUT);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DONE_TIMEOUT - 1);

  rst_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              soft_rst_n_reg, soft_rst_n_next;
  logic              busy_reg;
  logic [1:0]        cause_reg, cause_next;
  logic [7:0]        rst_cnt_reg, rst_cnt_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              timeout_set;

  logic wdt_run;
  logic wdt_expire;
  logic trigger;

  assign wdt_run = bus.i_wdt_en && (state_reg == IDLE);
  assign trigger = bus.i_sw_rst_req || wdt_expire;

  rst_wdt #(
    .WDT_LIMIT (WDT_LIMIT)
  ) u_wdt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (wdt_run),
    .i_kick   (bus.i_wdt_kick),
    .o_expire (wdt_expire)
  );

  // Next-state and registered-output decode for the request sequence.
  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    soft_rst_n_next = soft_rst_n_reg;
    cause_next      = cause_reg;
    rst_cnt_next    = rst_cnt_reg;
    timeout_set     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          cause_next[CAUSE_SW]  = bus.i_sw_rst_req;
          cause_next[CAUSE_WDT] = wdt_expire;
          if (rst_cnt_reg != 8'hFF) begin
            rst_cnt_next = rst_cnt_reg + 8'd1;
          end
          hold_cnt_next   = '0;
          soft_rst_n_next = 1'b0;
          state_next      = HOLD;
        end
      end

      HOLD: begin
        // Requests arriving here are dropped on purpose: the reset in flight
        // already covers them.
        if (hold_cnt_reg == HOLD_LAST) begin
          soft_rst_n_next = 1'b1;
          wait_cnt_next   = '0;
          state_next      = WAIT_DONE;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end

      WAIT_DONE: begin
        // wait_cnt is zero on the release cycle, where a stale done from the
        // synchronizer chain must not be trusted.
        if (bus.i_rst_done && (wait_cnt_reg != '0)) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end

      default: begin
        soft_rst_n_next = 1'b1;
        state_next      = IDLE;
      end
    endcase

    // A fresh timeout outranks a clear in the same cycle.
    if (timeout_set) begin
      timeout_err_next = 1'b1;
    end else if (bus.i_err_clr) begin
      timeout_err_next = 1'b0;
    end else begin
      timeout_err_next = timeout_err_reg;
    end
  end

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      wait_cnt_reg    <= '0;
      soft_rst_n_reg  <= 1'b1;
      busy_reg        <= 1'b0;
      cause_reg       <= 2'b00;
      rst_cnt_reg     <= 8'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      wait_cnt_reg    <= wait_cnt_next;
      soft_rst_n_reg  <= soft_rst_n_next;
      busy_reg        <= (state_next != IDLE);
      cause_reg       <= cause_next;
      rst_cnt_reg     <= rst_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign bus.o_soft_rst_n  = soft_rst_n_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_rst_cause   = cause_reg;
  assign bus.o_rst_cnt     = rst_cnt_reg;
  assign bus.o_timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed bench for rst_req_ctrl with a shortened watchdog limit.
module tb_rst_req_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  rst_req_ctrl_if bus();

  rst_req_ctrl #(
    .HOLD_CYCLES  (16),
    .DONE_TIMEOUT (1024),
    .WDT_LIMIT    (24'd100)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Safety net against a hung sequence.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sw();
    bus.i_sw_rst_req = 1'b1;
    step();
    bus.i_sw_rst_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.o_busy && n < budget) begin
      step();
      n++;
    end
    check_val("wait_idle", {31'd0, bus.o_busy}, 0);
  endtask

  // Host reset with core done held low; optionally clear in the timeout cycle.
  task automatic run_timeout(input logic clr_at_end, input string tag);
    bus.i_rst_done = 1'b0;
    pulse_sw();
    repeat (16) step();
    check_val({tag, "_released"}, {31'd0, bus.o_soft_rst_n}, 1);
    repeat (1023) step();
    check_val({tag, "_err_pre"}, {31'd0, bus.o_timeout_err}, 0);
    check_val({tag, "_busy_pre"}, {31'd0, bus.o_busy}, 1);
    bus.i_err_clr = clr_at_end;
    step();
    bus.i_err_clr = 1'b0;
    check_val({tag, "_err"}, {31'd0, bus.o_timeout_err}, 1);
    check_val({tag, "_busy"}, {31'd0, bus.o_busy}, 0);
    bus.i_rst_done = 1'b1;
  endtask

  initial begin
    int low;
    int lows;
    int early;

    bus.i_sw_rst_req = 1'b0;
    bus.i_wdt_en     = 1'b0;
    bus.i_wdt_kick   = 1'b0;
    bus.i_rst_done   = 1'b0;
    bus.i_err_clr    = 1'b0;

    // Power-on reset
    repeat (3) step();
    rst = 1'b0;
    check_val("por_soft_rst_n", {31'd0, bus.o_soft_rst_n}, 1);
    check_val("por_busy", {31'd0, bus.o_busy}, 0);
    check_val("por_cnt", {24'd0, bus.o_rst_cnt}, 0);
    check_val("por_cause", {30'd0, bus.o_rst_cause}, 0);
    check_val("por_terr", {31'd0, bus.o_timeout_err}, 0);

    // Host request: 16-cycle low pulse, done returns 5 cycles after release
    repeat (6) step();
    pulse_sw();
    exp_cnt++;
    check_val("sw_busy_hold", {31'd0, bus.o_busy}, 1);
    low = 0;
    while (bus.o_soft_rst_n == 1'b0 && low < 100) begin
      low++;
      step();
    end
    check_val("sw_low_width", low, 16);
    check_val("sw_cause", {30'd0, bus.o_rst_cause}, 2'b01);
    check_val("sw_cnt", {24'd0, bus.o_rst_cnt}, exp_cnt);
    repeat (5) step();
    check_val("sw_busy_before_done", {31'd0, bus.o_busy}, 1);
    bus.i_rst_done = 1'b1;
    step();
    check_val("sw_busy_after_done", {31'd0, bus.o_busy}, 0);

    // Done already high at release is ignored for exactly the release cycle
    pulse_sw();
    exp_cnt++;
    repeat (16) step();
    check_val("rel_soft_high", {31'd0, bus.o_soft_rst_n}, 1);
    step();
    check_val("rel_busy_r1", {31'd0, bus.o_busy}, 1);
    step();
    check_val("rel_busy_r2", {31'd0, bus.o_busy}, 0);

    // Watchdog expiry 100 cycles after enable
    bus.i_wdt_en = 1'b1;
    early = 0;
    for (int i = 1; i < 100; i++) begin
      step();
      if (bus.o_soft_rst_n == 1'b0) early++;
    end
    check_val("wdt_no_early", early, 0);
    step();
    bus.i_wdt_en = 1'b0;
    exp_cnt++;
    check_val("wdt_soft_low", {31'd0, bus.o_soft_rst_n}, 0);
    check_val("wdt_cause", {30'd0, bus.o_rst_cause}, 2'b10);
    check_val("wdt_cnt", {24'd0, bus.o_rst_cnt}, exp_cnt);
    wait_idle(100);

    // Kicked every 50 cycles: no reset over 1000 cycles
    bus.i_wdt_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      bus.i_wdt_kick = ((i % 50) == 49);
      step();
      if (bus.o_soft_rst_n == 1'b0) lows++;
    end
    bus.i_wdt_kick = 1'b0;
    bus.i_wdt_en   = 1'b0;
    check_val("kick50_no_reset", lows, 0);
    check_val("kick50_cnt", {24'd0, bus.o_rst_cnt}, exp_cnt);

    // Kick on the exact expiry cycle
    step();
    bus.i_wdt_en = 1'b1;
    repeat (99) step();
    bus.i_wdt_kick = 1'b1;
    step();
    bus.i_wdt_kick = 1'b0;
    bus.i_wdt_en   = 1'b0;
    check_val("kick_exp_soft", {31'd0, bus.o_soft_rst_n}, 1);
    check_val("kick_exp_busy", {31'd0, bus.o_busy}, 0);

    // Host request coinciding with watchdog expiry, then a dropped request in HOLD
    step();
    bus.i_wdt_en = 1'b1;
    repeat (99) step();
    pulse_sw();
    bus.i_wdt_en = 1'b0;
    exp_cnt++;
    check_val("both_soft_low", {31'd0, bus.o_soft_rst_n}, 0);
    check_val("both_cause", {30'd0, bus.o_rst_cause}, 2'b11);
    check_val("both_cnt", {24'd0, bus.o_rst_cnt}, exp_cnt);
    step();
    pulse_sw();
    wait_idle(100);
    check_val("hold_req_cnt", {24'd0, bus.o_rst_cnt}, exp_cnt);
    check_val("hold_req_cause", {30'd0, bus.o_rst_cause}, 2'b11);

    // Done timeout, clear, and set beating a coincident clear
    run_timeout(1'b0, "tmo1");
    exp_cnt++;
    bus.i_err_clr = 1'b1;
    step();
    bus.i_err_clr = 1'b0;
    check_val("tmo1_cleared", {31'd0, bus.o_timeout_err}, 0);
    run_timeout(1'b1, "tmo2");
    exp_cnt++;
    check_val("tmo_cnt", {24'd0, bus.o_rst_cnt}, exp_cnt);
    bus.i_err_clr = 1'b1;
    step();
    bus.i_err_clr = 1'b0;
    check_val("tmo2_cleared", {31'd0, bus.o_timeout_err}, 0);

    // 260 back-to-back host resets saturate the count
    for (int i = 0; i < 260; i++) begin
      pulse_sw();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      wait_idle(100);
    end
    check_val("sat_cnt", {24'd0, bus.o_rst_cnt}, 255);

    // Reset during HOLD aborts the sequence
    pulse_sw();
    repeat (3) step();
    check_val("abort_pre_low", {31'd0, bus.o_soft_rst_n}, 0);
    rst = 1'b1;
    step();
    check_val("abort_soft", {31'd0, bus.o_soft_rst_n}, 1);
    rst = 1'b0;
    check_val("abort_cnt", {24'd0, bus.o_rst_cnt}, 0);
    check_val("abort_busy", {31'd0, bus.o_busy}, 0);
    check_val("abort_cause", {30'd0, bus.o_rst_cause}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
